// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller between NSRC asynchronous interrupt lines and the
//   fetch unit. Each line is synchronized and rising-edge detected. An edge
//   latches a pending bit. A three-state FSM (IDLE/REQ/SERVICE) presents the
//   lowest-index enabled pending source to fetch, and waits for fetch to
//   accept it. The request is withdrawn if fetch does not accept it within
//   ACK_TIMEOUT cycles.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous, active-high reset
//   irq_in    raw interrupt lines (asynchronous, rising-edge significant)
//   mask_we   enable-mask write strobe
//   mask_in   new enable mask (1 = source enabled)
//   int_ack   one-cycle pulse from fetch: interrupt accepted
//   int_done  level from fetch: return-from-interrupt reached fetch
//   ipu_int   registered interrupt request to fetch
//   irq_id    index of the source being requested / serviced
//   pending   latched pending bits
//   busy      high while in REQ or SERVICE
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int NSRC        = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         irq_in,
    input  logic                    mask_we,
    input  logic [NSRC-1:0]         mask_in,
    input  logic                    int_ack,
    input  logic                    int_done,
    output logic                    ipu_int,
    output logic [$clog2(NSRC)-1:0] irq_id,
    output logic [NSRC-1:0]         pending,
    output logic                    busy
);

    localparam int ID_W  = $clog2(NSRC);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ID_W-1:0]   id_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;

    logic [NSRC-1:0]   sync_p0;
    logic [NSRC-1:0]   sync_p1;
    logic [NSRC-1:0]   sync_p2;
    logic              vld_p0;
    logic              vld_p1;
    logic [NSRC-1:0]   armed;
    logic [NSRC-1:0]   mask;

    logic [NSRC-1:0]   edge_det;
    logic [NSRC-1:0]   req_vec;
    logic [NSRC-1:0]   ack_clr;

    // Lowest set index of a request vector; zero when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NSRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer; p2: edge-detect history ----
    // vld_p1 marks that sync_p1 holds a real sample rather than the reset
    // value. A line is only armed once a genuine low has been seen, so a line
    // already high across reset does not fire until it drops and rises again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= '0;
        end else begin
            sync_p0 <= irq_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            armed   <= armed | (~sync_p1 & {NSRC{vld_p1}});
        end
    end

    assign edge_det = sync_p1 & ~sync_p2 & armed;
    assign req_vec  = pending & mask;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = (state == REQ) && int_ack && (irq_id == ID_W'(i));
        end
    end

    // ---- pending latch and enable mask ----
    // A new edge on the acknowledged source wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '1;
        end else begin
            pending <= (pending & ~ack_clr) | edge_det;
            if (mask_we) mask <= mask_in;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        state_nx = state;
        id_nx    = irq_id;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (|req_vec) begin
                    id_nx    = lowest_idx(req_vec);
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nx = SERVICE;
                    cnt_nx   = '0;
                end else if (cnt == TO_LAST) begin
                    // Withdraw; the pending bit stays and is re-arbitrated.
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            SERVICE: begin
                if (int_done) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // ---- FSM state and registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_id  <= '0;
            cnt     <= '0;
            ipu_int <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            irq_id  <= id_nx;
            cnt     <= cnt_nx;
            ipu_int <= (state_nx == REQ);
            busy    <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
//   Directed self-checking bench for irq_ctrl (NSRC=4, ACK_TIMEOUT=15).
//   Inputs change 1 ns after a rising edge; outputs are observed at that
//   same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_done;
    logic       ipu_int;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       busy;

    int checks;
    int errors;

    irq_ctrl #(
        .NSRC        (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .mask_we  (mask_we),
        .mask_in  (mask_in),
        .int_ack  (int_ack),
        .int_done (int_done),
        .ipu_int  (ipu_int),
        .irq_id   (irq_id),
        .pending  (pending),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        irq_in   = '0;
        mask_we  = 1'b0;
        mask_in  = '0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        tick(2);
        checks++;
        if (ipu_int !== 1'b0) begin
            errors++; $display("FAIL reset_ipu_int: got %0b want 0", ipu_int);
        end
        checks++;
        if (irq_id !== 2'd0) begin
            errors++; $display("FAIL reset_irq_id: got %0d want 0", irq_id);
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL reset_pending: got %b want 0000", pending);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b want 0", busy);
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single;
        irq_in = 4'b0100;
        tick(3);
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0100) begin
            errors++; $display("FAIL single_edge3: ipu_int=%0b pending=%b want 0/0100", ipu_int, pending);
        end
        tick(1);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL single_req: ipu_int=%0b irq_id=%0d busy=%0b want 1/2/1", ipu_int, irq_id, busy);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL single_ack: ipu_int=%0b pending=%b busy=%0b want 0/0000/1", ipu_int, pending, busy);
        end
        tick(2);
        checks++;
        if (busy !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL single_service_hold: busy=%0b irq_id=%0d want 1/2", busy, irq_id);
        end
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL single_done: busy=%0b ipu_int=%0b want 0/0", busy, ipu_int);
        end
        irq_in = '0;
        tick(4);
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0000) begin
            errors++; $display("FAIL single_no_retrigger: ipu_int=%0b pending=%b want 0/0000", ipu_int, pending);
        end
    endtask

    task automatic test_priority;
        irq_in = 4'b1010;
        tick(4);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b1010) begin
            errors++; $display("FAIL prio_first: ipu_int=%0b irq_id=%0d pending=%b want 1/1/1010", ipu_int, irq_id, pending);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("FAIL prio_ack: pending=%b busy=%0b want 1000/1", pending, busy);
        end
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        checks++;
        if (ipu_int !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL prio_idle_gap: ipu_int=%0b busy=%0b want 0/0", ipu_int, busy);
        end
        tick(1);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd3) begin
            errors++; $display("FAIL prio_second: ipu_int=%0b irq_id=%0d want 1/3", ipu_int, irq_id);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        irq_in = '0;
        tick(4);
        checks++;
        if (pending !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL prio_end: pending=%b busy=%0b want 0000/0", pending, busy);
        end
    endtask

    task automatic test_timeout;
        irq_in = 4'b0001;
        tick(4);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL to_req: ipu_int=%0b irq_id=%0d want 1/0", ipu_int, irq_id);
        end
        tick(14);
        checks++;
        if (ipu_int !== 1'b1) begin
            errors++; $display("FAIL to_held14: ipu_int=%0b want 1", ipu_int);
        end
        tick(1);
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL to_withdraw: ipu_int=%0b pending=%b busy=%0b want 0/0001/0", ipu_int, pending, busy);
        end
        tick(1);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL to_rerequest: ipu_int=%0b irq_id=%0d want 1/0", ipu_int, irq_id);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        irq_in = '0;
        tick(4);
    endtask

    task automatic test_mask;
        mask_in = 4'b1110;
        mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        irq_in = 4'b0001;
        tick(4);
        checks++;
        if (pending !== 4'b0001 || ipu_int !== 1'b0) begin
            errors++; $display("FAIL mask_blocked: pending=%b ipu_int=%0b want 0001/0", pending, ipu_int);
        end
        tick(3);
        checks++;
        if (ipu_int !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mask_still_blocked: ipu_int=%0b busy=%0b want 0/0", ipu_int, busy);
        end
        mask_in = 4'b1111;
        mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        checks++;
        if (ipu_int !== 1'b0) begin
            errors++; $display("FAIL mask_write_edge: ipu_int=%0b want 0", ipu_int);
        end
        tick(1);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL mask_enabled: ipu_int=%0b irq_id=%0d want 1/0", ipu_int, irq_id);
        end
        // Masking the source mid-request must not abort it.
        mask_in = 4'b0000;
        mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd0) begin
            errors++; $display("FAIL mask_no_abort: ipu_int=%0b irq_id=%0d want 1/0", ipu_int, irq_id);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        mask_in = 4'b1111;
        mask_we = 1'b1;
        tick(1);
        mask_we = 1'b0;
        irq_in = '0;
        tick(4);
    endtask

    task automatic test_coincident;
        irq_in = 4'b0100;
        tick(4);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL coin_req: ipu_int=%0b irq_id=%0d want 1/2", ipu_int, irq_id);
        end
        irq_in = 4'b0000;
        tick(1);
        irq_in = 4'b0100;
        tick(2);
        // The new edge is detected in this cycle, together with the ack.
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'b0100 || ipu_int !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL coin_set_wins: pending=%b ipu_int=%0b busy=%0b want 0100/0/1", pending, ipu_int, busy);
        end
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(1);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd2) begin
            errors++; $display("FAIL coin_reserve: ipu_int=%0b irq_id=%0d want 1/2", ipu_int, irq_id);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        irq_in = '0;
        tick(4);
        checks++;
        if (pending !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL coin_end: pending=%b busy=%0b want 0000/0", pending, busy);
        end
    endtask

    task automatic test_reset_mid;
        // Reset during REQ: ipu_int must drop before any clock edge.
        irq_in = 4'b0100;
        tick(4);
        rst = 1'b1;
        #2;
        checks++;
        if (ipu_int !== 1'b0 || busy !== 1'b0 || pending !== 4'b0000 || irq_id !== 2'd0) begin
            errors++; $display("FAIL rstreq_async: ipu_int=%0b busy=%0b pending=%b irq_id=%0d want 0/0/0000/0", ipu_int, busy, pending, irq_id);
        end
        tick(1);
        rst = 1'b0;
        irq_in = '0;
        tick(4);
        // Reset during SERVICE with source 3 still pending.
        irq_in = 4'b1010;
        tick(4);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("FAIL rstsvc_setup: pending=%b busy=%0b want 1000/1", pending, busy);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (ipu_int !== 1'b0 || busy !== 1'b0 || pending !== 4'b0000) begin
            errors++; $display("FAIL rstsvc_async: ipu_int=%0b busy=%0b pending=%b want 0/0/0000", ipu_int, busy, pending);
        end
        tick(1);
        rst = 1'b0;
        tick(8);
        checks++;
        if (ipu_int !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_edge_high: ipu_int=%0b pending=%b busy=%0b want 0/0000/0", ipu_int, pending, busy);
        end
        irq_in = 4'b0000;
        tick(4);
        irq_in = 4'b1000;
        tick(4);
        checks++;
        if (ipu_int !== 1'b1 || irq_id !== 2'd3) begin
            errors++; $display("FAIL rst_new_edge: ipu_int=%0b irq_id=%0d want 1/3", ipu_int, irq_id);
        end
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        irq_in = '0;
        tick(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_mask();
        test_coincident();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: NSRC, 4, number of interrupt source lines (2..8).
REQ-002 Parameter: ACK_TIMEOUT, 15, maximum cycles ipu_int is held without int_ack before it is withdrawn.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 irq_in  input  NSRC  raw interrupt source lines, asynchronous to clk, rising-edge significant.
REQ-006 mask_we  input  1  write strobe for the enable mask.
REQ-007 mask_in  input  NSRC  new enable mask; bit=1 enables that source.
REQ-008 int_ack  input  1  one-cycle pulse from fetch: interrupt accepted.
REQ-009 int_done  input  1  level from fetch: return-from-interrupt instruction is in fetch.
REQ-010 ipu_int  output  1  registered interrupt request to fetch.
REQ-011 irq_id  output  clog2(NSRC)  index of the source being requested or serviced.
REQ-012 pending  output  NSRC  latched pending bits.
REQ-013 busy  output  1  high in REQ or SERVICE state.

Function
REQ-014 Each irq_in bit SHALL pass a 2-flop synchronizer, then a third flop for edge detection; edge = sync2 & ~sync3.
REQ-015 A detected edge SHALL set the matching pending bit on the next clk edge, regardless of mask.
REQ-016 Pending bit i SHALL clear on the clk edge where int_ack is sampled in REQ with irq_id==i; if a new edge on i coincides, set wins (bit stays 1).
REQ-017 mask SHALL load mask_in on a clk edge with mask_we=1, effective for arbitration the following cycle; masking never clears pending.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE: if (pending & mask) nonzero, select lowest set index, latch irq_id, go REQ, ipu_int=1 from the same edge.
REQ-020 REQ: hold ipu_int=1 and irq_id stable; int_done ignored.
REQ-021 REQ with int_ack=1: ipu_int=0, clear pending[irq_id], go SERVICE, clear timeout counter.
REQ-022 REQ with no int_ack for ACK_TIMEOUT consecutive cycles: ipu_int=0, return IDLE, pending bit kept (re-arbitrated, earliest re-request one cycle later).
REQ-023 SERVICE: ipu_int=0; irq_id holds; int_ack ignored; int_done=1 returns to IDLE.
REQ-024 Transition IDLE->REQ SHALL NOT occur on the same edge as SERVICE->IDLE; minimum one IDLE cycle between services.
REQ-025 Mask change during REQ or SERVICE SHALL NOT abort the current request.
REQ-026 Latency: irq_in rising and stable, enabled, FSM in IDLE -> ipu_int=1 after the 4th rising clk edge, counting the first edge that samples irq_in high.
REQ-027 irq_in held high produces one edge only; a new request requires a low-then-high transition.
REQ-028 Timeout counter width SHALL be clog2(ACK_TIMEOUT+1); no wrap (saturates at timeout).

Reset
REQ-029 On rst: state=IDLE, ipu_int=0, irq_id=0, pending=0, busy=0, mask=all ones, synchronizer and edge flops=0, timeout counter=0.
REQ-030 rst asserted mid-REQ or mid-SERVICE SHALL drop ipu_int immediately (asynchronously) and discard all pending requests.
REQ-031 After rst deasserts, irq_in lines already high SHALL NOT generate an edge until they go low then high.

Verification
REQ-032 Single: irq_in=4'b0100 rising -> ipu_int=1 after 4th edge, irq_id=2; int_ack pulse -> ipu_int=0, pending=0, busy=1; int_done -> busy=0 next edge.
REQ-033 Priority: irq_in bits 3 and 1 rise same cycle -> irq_id=1 served first; after int_done + 1 IDLE cycle, irq_id=3 requested.
REQ-034 Timeout: ACK_TIMEOUT=15, request raised, no int_ack -> ipu_int falls after 15 cycles high, pending[id] still 1, ipu_int re-asserts 1 cycle later.
REQ-035 Mask: mask=4'b1110, irq_in[0] rises -> pending=4'b0001, ipu_int stays 0; write mask=4'b1111 -> ipu_int=1, irq_id=0 two edges after the write edge.
REQ-036 Reset mid-operation: rst pulsed during SERVICE with pending=4'b1000 -> ipu_int=0, pending=0, busy=0, no request until a new irq_in edge.
REQ-037 Coincident set/clear: edge on source 2 on the same cycle as int_ack for irq_id=2 -> pending[2]=1 after the edge, re-served after int_done.
